// File: rtl/gbc_bus_pkg.sv
// Shared types and constants for the GBC memory-bus arbiter slice.
// Pure declarations: no latency, no backpressure.
package gbc_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam int REQ_CPU    = 0;
  localparam int REQ_OAMDMA = 1;
  localparam int REQ_HDMA   = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } arb_state_e;

endpackage

// File: rtl/gbc_prio_encoder.sv
// Highest-set-bit encoder: idx is the highest asserted request, vld says any is set.
// Purely combinational (0 cycles); no backpressure.
module gbc_prio_encoder #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = IW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gbc_bus_arbiter.sv
// Fixed-priority, cycle-locked Wishbone arbiter for the GBC memory bus (1-cycle grant, GAP cycle on release).
// Non-owners always stall; owner stalls on target stall or MAX_OUTSTANDING. Watchdog: GBC_BUS_ARB_WATCHDOG_EN.
import gbc_bus_pkg::*;

module gbc_bus_arbiter #(
  parameter int N_REQ           = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [N_REQ-1:0]           req_cyc,
  input  logic [N_REQ-1:0]           req_stb,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [ADDR_W*N_REQ-1:0]    req_addr,
  input  logic [DATA_W*N_REQ-1:0]    req_wdata,
  output logic [N_REQ-1:0]           req_ack,
  output logic [N_REQ-1:0]           req_stall,
  output logic [DATA_W-1:0]          req_rdata,
  output logic                       t_cyc,
  output logic                       t_stb,
  output logic                       t_we,
  output logic [ADDR_W-1:0]          t_addr,
  output logic [DATA_W-1:0]          t_wdata,
  input  logic                       t_ack,
  input  logic                       t_stall,
  input  logic [DATA_W-1:0]          t_rdata,
  output logic [$clog2(N_REQ)-1:0]   grant,
  output logic                       busy,
  output logic                       err
);

  localparam int GW = $clog2(N_REQ);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] OS_ONE = OW'(1);

  arb_state_e    state, state_nxt;
  logic [GW-1:0] grant_nxt;
  logic [OW-1:0] outstanding, outstanding_nxt;
  logic [GW-1:0] pe_idx;
  logic          pe_vld;
  logic          os_full, accept, dec, wd_fire;

  gbc_prio_encoder #(.N(N_REQ), .IW(GW)) u_prio (
    .req (req_cyc),
    .idx (pe_idx),
    .vld (pe_vld)
  );

  assign busy    = (state == BUSY);
  assign os_full = (outstanding == MAX_OS);
  assign accept  = t_stb & ~t_stall;
  // A late target ACK with nothing pending must not wrap the counter.
  assign dec     = busy & ((t_ack & (outstanding != '0)) | wd_fire);

  always_comb begin
    t_cyc     = 1'b0;
    t_stb     = 1'b0;
    t_we      = 1'b0;
    t_addr    = '0;
    t_wdata   = '0;
    req_ack   = '0;
    req_stall = '1;
    if (busy) begin
      t_cyc            = req_cyc[grant];
      t_stb            = req_stb[grant] & ~os_full;
      t_we             = req_we[grant];
      t_addr           = req_addr[grant*ADDR_W +: ADDR_W];
      t_wdata          = req_wdata[grant*DATA_W +: DATA_W];
      req_stall[grant] = t_stall | os_full;
      req_ack[grant]   = t_ack | wd_fire;
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    outstanding_nxt = outstanding;
    case (state)
      IDLE: begin
        if (pe_vld) begin
          grant_nxt = pe_idx;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!req_cyc[grant]) begin
          state_nxt       = GAP;
          outstanding_nxt = '0;
        end else if (accept && !dec) begin
          outstanding_nxt = outstanding + OS_ONE;
        end else if (!accept && dec) begin
          outstanding_nxt = outstanding - OS_ONE;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      grant       <= '0;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      outstanding <= outstanding_nxt;
    end
  end

`ifdef GBC_BUS_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_ONE = WW'(1);

  logic [WW-1:0] wd_cnt;
  logic          err_q;

  // The synthetic ACK retires one stuck transfer with all-ones read data.
  assign wd_fire   = busy & (outstanding != '0) & ~t_ack & (wd_cnt == WD_LIM);
  assign err       = err_q;
  assign req_rdata = wd_fire ? 8'hFF : t_rdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!busy || t_ack || wd_fire || outstanding == '0) wd_cnt <= '0;
      else                                                wd_cnt <= wd_cnt + WD_ONE;
      if (wd_fire) err_q <= 1'b1;
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign err       = 1'b0;
  assign req_rdata = t_rdata;
`endif

endmodule

// File: tb/tb_gbc_bus_arbiter.sv
// Directed bench for gbc_bus_arbiter: grant, priority, cycle-lock, outstanding limit, abort, reset, watchdog.
module tb_gbc_bus_arbiter;
  import gbc_bus_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [2:0]  req_cyc, req_stb, req_we;
  logic [47:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  req_ack, req_stall;
  logic [7:0]  req_rdata;
  logic        t_cyc, t_stb, t_we;
  logic [15:0] t_addr;
  logic [7:0]  t_wdata;
  logic        t_ack, t_stall;
  logic [7:0]  t_rdata;
  logic [1:0]  grant;
  logic        busy, err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  gbc_bus_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_cyc(req_cyc), .req_stb(req_stb), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_stall(req_stall), .req_rdata(req_rdata),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_ack(t_ack), .t_stall(t_stall), .t_rdata(t_rdata),
    .grant(grant), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [15:0] a, input logic [7:0] d);
    req_cyc[i]           = cyc;
    req_stb[i]           = stb;
    req_we[i]            = we;
    req_addr[i*16 +: 16] = a;
    req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    req_cyc = '0; req_stb = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    t_ack = 1'b0; t_stall = 1'b0; t_rdata = 8'h00;
    #12;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (grant !== 2'd0) $display("FAIL rst_grant got %0d want 0", grant); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if ({t_cyc, t_stb} !== 2'b00) $display("FAIL rst_tcyc_tstb got %b want 00", {t_cyc, t_stb}); else pass_cnt++;
    total_cnt++; if (req_ack !== 3'b000) $display("FAIL rst_ack got %b want 000", req_ack); else pass_cnt++;
    total_cnt++; if (req_stall !== 3'b111) $display("FAIL rst_stall got %b want 111", req_stall); else pass_cnt++;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_cpu_only();
    drive(REQ_CPU, 1'b1, 1'b1, 1'b1, 16'hFF80, 8'h5A);
    settle();
    total_cnt++; if (busy !== 1'b0 || t_cyc !== 1'b0) $display("FAIL cpu_idle busy=%b t_cyc=%b want 0 0", busy, t_cyc); else pass_cnt++;
    total_cnt++; if (req_stall !== 3'b111) $display("FAIL cpu_idle_stall got %b want 111", req_stall); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b1 || grant !== 2'd0) $display("FAIL cpu_grant busy=%b grant=%0d want 1 0", busy, grant); else pass_cnt++;
    total_cnt++; if (t_addr !== 16'hFF80 || t_wdata !== 8'h5A || t_we !== 1'b1)
      $display("FAIL cpu_fwd addr=%h wdata=%h we=%b want ff80 5a 1", t_addr, t_wdata, t_we); else pass_cnt++;
    total_cnt++; if (t_cyc !== 1'b1 || t_stb !== 1'b1) $display("FAIL cpu_cyc_stb got %b%b want 11", t_cyc, t_stb); else pass_cnt++;
    t_stall = 1'b1; settle();
    total_cnt++; if (req_stall !== 3'b111) $display("FAIL cpu_tstall got %b want 111", req_stall); else pass_cnt++;
    t_stall = 1'b0; settle();
    total_cnt++; if (req_stall !== 3'b110) $display("FAIL cpu_stall got %b want 110", req_stall); else pass_cnt++;
    tick();
    drive(REQ_CPU, 1'b1, 1'b0, 1'b1, 16'hFF80, 8'h5A);
    t_ack = 1'b1; t_rdata = 8'hA5; settle();
    total_cnt++; if (req_ack !== 3'b001) $display("FAIL cpu_ack got %b want 001", req_ack); else pass_cnt++;
    total_cnt++; if (req_rdata !== 8'hA5) $display("FAIL cpu_rdata got %h want a5", req_rdata); else pass_cnt++;
    tick();
    t_ack = 1'b0; settle();
    total_cnt++; if (req_ack !== 3'b000) $display("FAIL cpu_ack_once got %b want 000", req_ack); else pass_cnt++;
    drive(REQ_CPU, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    total_cnt++; if (busy !== 1'b0 || t_cyc !== 1'b0 || req_stall !== 3'b111)
      $display("FAIL cpu_gap busy=%b t_cyc=%b stall=%b want 0 0 111", busy, t_cyc, req_stall); else pass_cnt++;
    tick();
  endtask

  task automatic test_priority();
    drive(REQ_CPU, 1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
    drive(REQ_HDMA, 1'b1, 1'b0, 1'b0, 16'h8000, 8'h00);
    tick();
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (busy !== 1'b1 || grant !== 2'd2 || req_stall[0] !== 1'b1)
        $display("FAIL prio_hdma[%0d] busy=%b grant=%0d stall0=%b want 1 2 1", k, busy, grant, req_stall[0]); else pass_cnt++;
      tick();
    end
    drive(REQ_HDMA, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    total_cnt++; if (busy !== 1'b0 || req_stall[0] !== 1'b1) $display("FAIL prio_gap busy=%b stall0=%b want 0 1", busy, req_stall[0]); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL prio_idle busy=%b want 0", busy); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b1 || grant !== 2'd0) $display("FAIL prio_cpu busy=%b grant=%0d want 1 0", busy, grant); else pass_cnt++;
    drive(REQ_CPU, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick();
  endtask

  task automatic test_no_preempt();
    drive(REQ_CPU, 1'b1, 1'b0, 1'b0, 16'hC000, 8'h00);
    tick();
    drive(REQ_OAMDMA, 1'b1, 1'b0, 1'b0, 16'hFE00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++; if (busy !== 1'b1 || grant !== 2'd0) $display("FAIL nopre_hold[%0d] busy=%b grant=%0d want 1 0", k, busy, grant); else pass_cnt++;
    end
    drive(REQ_CPU, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick(); tick();
    total_cnt++; if (busy !== 1'b1 || grant !== 2'd1) $display("FAIL nopre_oam busy=%b grant=%0d want 1 1", busy, grant); else pass_cnt++;
    drive(REQ_OAMDMA, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick();
  endtask

  task automatic test_outstanding();
    int acc;
    acc = 0;
    drive(REQ_OAMDMA, 1'b1, 1'b1, 1'b0, 16'hC100, 8'h00);
    tick();
    for (int k = 0; k < 6; k++) begin
      total_cnt++; if (t_stb !== (k < 4)) $display("FAIL os_stb[%0d] got %b want %b", k, t_stb, (k < 4)); else pass_cnt++;
      if (t_stb && !t_stall) acc++;
      tick();
    end
    total_cnt++; if (acc != 4) $display("FAIL os_accepted got %0d want 4", acc); else pass_cnt++;
    total_cnt++; if (req_stall[1] !== 1'b1) $display("FAIL os_full_stall got %b want 1", req_stall[1]); else pass_cnt++;
    t_ack = 1'b1; settle();
    total_cnt++; if (req_ack !== 3'b010 || t_stb !== 1'b0) $display("FAIL os_ack ack=%b stb=%b want 010 0", req_ack, t_stb); else pass_cnt++;
    tick();
    t_ack = 1'b0; settle();
    total_cnt++; if (t_stb !== 1'b1 || req_stall[1] !== 1'b0) $display("FAIL os_refill stb=%b stall=%b want 1 0", t_stb, req_stall[1]); else pass_cnt++;
    tick();
    total_cnt++; if (t_stb !== 1'b0 || req_stall[1] !== 1'b1) $display("FAIL os_refull stb=%b stall=%b want 0 1", t_stb, req_stall[1]); else pass_cnt++;
    drive(REQ_OAMDMA, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick();
  endtask

  task automatic test_abort();
    int acc;
    acc = 0;
    drive(REQ_CPU, 1'b1, 1'b1, 1'b0, 16'hD000, 8'h00);
    tick(); tick(); tick();
    total_cnt++; if (req_stall[0] !== 1'b0) $display("FAIL abort_two_os stall=%b want 0", req_stall[0]); else pass_cnt++;
    drive(REQ_CPU, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    settle();
    total_cnt++; if (t_cyc !== 1'b0) $display("FAIL abort_tcyc got %b want 0", t_cyc); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0 || t_cyc !== 1'b0) $display("FAIL abort_gap busy=%b t_cyc=%b want 0 0", busy, t_cyc); else pass_cnt++;
    tick();
    drive(REQ_CPU, 1'b1, 1'b1, 1'b0, 16'hD000, 8'h00);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (t_stb && !t_stall) acc++;
      tick();
    end
    total_cnt++; if (acc != 4) $display("FAIL abort_cleared accepted=%0d want 4", acc); else pass_cnt++;
    drive(REQ_CPU, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    drive(REQ_HDMA, 1'b1, 1'b1, 1'b0, 16'h9000, 8'h00);
    tick(); tick();
    t_ack = 1'b1; settle();
    total_cnt++; if (busy !== 1'b1 || grant !== 2'd2 || req_ack !== 3'b100)
      $display("FAIL rmid_pre busy=%b grant=%0d ack=%b want 1 2 100", busy, grant, req_ack); else pass_cnt++;
    RST_N = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || grant !== 2'd0) $display("FAIL rmid_state busy=%b grant=%0d want 0 0", busy, grant); else pass_cnt++;
    total_cnt++; if (req_ack !== 3'b000 || req_stall !== 3'b111)
      $display("FAIL rmid_req ack=%b stall=%b want 000 111", req_ack, req_stall); else pass_cnt++;
    total_cnt++; if ({t_cyc, t_stb} !== 2'b00) $display("FAIL rmid_target got %b want 00", {t_cyc, t_stb}); else pass_cnt++;
    t_ack = 1'b0;
    drive(REQ_HDMA, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_watchdog();
    int fired_at;
    fired_at = -1;
    drive(REQ_HDMA, 1'b1, 1'b1, 1'b0, 16'hA000, 8'h00);
    tick(); tick();
    drive(REQ_HDMA, 1'b1, 1'b0, 1'b0, 16'hA000, 8'h00);
    t_rdata = 8'h3C; settle();
    for (int n = 0; n < 200; n++) begin
      if (req_ack[2] === 1'b1) begin
        fired_at = n;
        break;
      end
      tick();
    end
`ifdef GBC_BUS_ARB_WATCHDOG_EN
    total_cnt++; if (fired_at != 64) $display("FAIL wd_time fired_at=%0d want 64", fired_at); else pass_cnt++;
    total_cnt++; if (req_rdata !== 8'hFF || err !== 1'b1) $display("FAIL wd_fire rdata=%h err=%b want ff 1", req_rdata, err); else pass_cnt++;
    tick();
    total_cnt++; if (req_ack !== 3'b000 || err !== 1'b1) $display("FAIL wd_after ack=%b err=%b want 000 1", req_ack, err); else pass_cnt++;
    total_cnt++; if (req_rdata !== 8'h3C) $display("FAIL wd_rdata_pass got %h want 3c", req_rdata); else pass_cnt++;
    drive(REQ_HDMA, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick(); tick();
    total_cnt++; if (err !== 1'b1) $display("FAIL wd_sticky err=%b want 1", err); else pass_cnt++;
`else
    total_cnt++; if (fired_at != -1) $display("FAIL nowd_ack fired_at=%0d want none", fired_at); else pass_cnt++;
    total_cnt++; if (err !== 1'b0 || req_rdata !== 8'h3C) $display("FAIL nowd_err err=%b rdata=%h want 0 3c", err, req_rdata); else pass_cnt++;
    drive(REQ_HDMA, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick();
`endif
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_priority();
    test_no_preempt();
    test_outstanding();
    test_abort();
    test_reset_mid();
    test_watchdog();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
